// File: rtl/tis_axi_port_bridge.sv
// -----------------------------------------------------------------------------
// tis_axi_port_bridge
//
// AXI4-Lite slave that connects the processor to N_CHAN TIS node ports. Each
// channel has a TX FIFO (processor -> node) and an RX FIFO (node -> processor).
// A register block adds per-channel status, sticky error flags, RX fill levels,
// FIFO flush control and a maskable, registered level-sensitive interrupt.
//
// Word map (addr[5:2]):
//   0..3  DATA[c]  write pushes TX FIFO c, read pops RX FIFO c (sign-extended)
//   4     STATUS   [c] rx_nonempty, [4+c] tx_notfull, [8+c] tx_drop (sticky),
//                  [12+c] rx_underflow (sticky); write 1 to [15:8] to clear
//   5     IRQ_EN   [c] rx_nonempty, [4+c] tx_notfull, [8] any sticky flag
//   6     LEVEL    byte c = RX FIFO c occupancy
//   7     CTRL     write bit c = 1 flushes both FIFOs of channel c; reads 0
//
// Ports:
//   S_AXI_*   AXI4-Lite slave (responses always OKAY)
//   tx_data   TX FIFO heads, channel c in slice c
//   tx_valid  TX FIFO c non-empty
//   tx_ready  node c pops its TX head on tx_valid[c] && tx_ready[c]
//   rx_data   node output words, channel c in slice c
//   rx_valid  node c offers a word
//   rx_ready  RX FIFO c can accept a word
//   irq       registered level-sensitive interrupt
// -----------------------------------------------------------------------------
module tis_axi_port_bridge #(
    parameter int C_S_AXI_DATA_WIDTH = 32,
    parameter int C_S_AXI_ADDR_WIDTH = 6,
    parameter int N_CHAN             = 2,
    parameter int FIFO_DEPTH         = 4,
    parameter int TIS_DATA_WIDTH     = 11
) (
    input  logic                               S_AXI_ACLK,
    input  logic                               S_AXI_ARESETN,
    input  logic [C_S_AXI_ADDR_WIDTH-1:0]      S_AXI_AWADDR,
    input  logic [2:0]                         S_AXI_AWPROT,
    input  logic                               S_AXI_AWVALID,
    output logic                               S_AXI_AWREADY,
    input  logic [C_S_AXI_DATA_WIDTH-1:0]      S_AXI_WDATA,
    input  logic [3:0]                         S_AXI_WSTRB,
    input  logic                               S_AXI_WVALID,
    output logic                               S_AXI_WREADY,
    output logic [1:0]                         S_AXI_BRESP,
    output logic                               S_AXI_BVALID,
    input  logic                               S_AXI_BREADY,
    input  logic [C_S_AXI_ADDR_WIDTH-1:0]      S_AXI_ARADDR,
    input  logic [2:0]                         S_AXI_ARPROT,
    input  logic                               S_AXI_ARVALID,
    output logic                               S_AXI_ARREADY,
    output logic [C_S_AXI_DATA_WIDTH-1:0]      S_AXI_RDATA,
    output logic [1:0]                         S_AXI_RRESP,
    output logic                               S_AXI_RVALID,
    input  logic                               S_AXI_RREADY,
    output logic [N_CHAN*TIS_DATA_WIDTH-1:0]   tx_data,
    output logic [N_CHAN-1:0]                  tx_valid,
    input  logic [N_CHAN-1:0]                  tx_ready,
    input  logic [N_CHAN*TIS_DATA_WIDTH-1:0]   rx_data,
    input  logic [N_CHAN-1:0]                  rx_valid,
    output logic [N_CHAN-1:0]                  rx_ready,
    output logic                               irq
);

    localparam int               PTR_W   = $clog2(FIFO_DEPTH);
    localparam int               CNT_W   = PTR_W + 1;
    localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(FIFO_DEPTH);

    localparam logic [3:0] IDX_STATUS = 4'd4;
    localparam logic [3:0] IDX_IRQ_EN = 4'd5;
    localparam logic [3:0] IDX_LEVEL  = 4'd6;
    localparam logic [3:0] IDX_CTRL   = 4'd7;

    logic        awready_q, wready_q, bvalid_q;
    logic        arready_q, rvalid_q;
    logic [31:0] rdata_q;
    logic [8:0]  irq_en_q;
    logic        irq_q, irq_d;
    logic        rst_done_q;
    logic [31:0] rd_val;
    logic [3:0]  widx, ridx;
    logic        wr_fire, rd_fire;

    logic [N_CHAN-1:0]                     rx_nonempty, tx_notfull, tx_drop, rx_unf;
    logic [N_CHAN-1:0][TIS_DATA_WIDTH-1:0] rx_head;
    logic [N_CHAN-1:0][CNT_W-1:0]          rx_count;

    assign widx = S_AXI_AWADDR[5:2];
    assign ridx = S_AXI_ARADDR[5:2];

    // A write commits on the edge where both channels are offered and no
    // transaction is in flight; a read likewise when no read is in flight.
    assign wr_fire = S_AXI_AWVALID && S_AXI_WVALID && !awready_q && !bvalid_q;
    assign rd_fire = S_AXI_ARVALID && !arready_q && !rvalid_q;

    // -------------------------------------------------------------------------
    // Per-channel FIFOs and sticky flags
    // -------------------------------------------------------------------------
    for (genvar c = 0; c < N_CHAN; c++) begin : g_chan
        logic [TIS_DATA_WIDTH-1:0] tx_mem [FIFO_DEPTH];
        logic [TIS_DATA_WIDTH-1:0] rx_mem [FIFO_DEPTH];
        logic [PTR_W-1:0]          tx_wp_q, tx_rp_q, rx_wp_q, rx_rp_q;
        logic [CNT_W-1:0]          tx_cnt_q, rx_cnt_q;
        logic                      tx_drop_q, rx_unf_q;
        logic                      flush, tx_pop, tx_push_req, tx_push;
        logic                      rx_rdy, rx_push, rx_pop_req, rx_pop;

        assign flush       = wr_fire && (widx == IDX_CTRL) && S_AXI_WDATA[c];
        assign tx_pop      = (tx_cnt_q != '0) && tx_ready[c];
        assign tx_push_req = wr_fire && (widx == 4'(c));
        // A full TX FIFO still takes the word if the node frees a slot this edge.
        assign tx_push     = tx_push_req && ((tx_cnt_q != DEPTH_C) || tx_pop);
        assign rx_rdy      = rst_done_q && (rx_cnt_q != DEPTH_C);
        assign rx_push     = rx_valid[c] && rx_rdy;
        assign rx_pop_req  = rd_fire && (ridx == 4'(c));
        assign rx_pop      = rx_pop_req && (rx_cnt_q != '0);

        // NOTE: sequential state uses non-blocking assignments so every flop
        // samples pre-edge values regardless of statement order.
        always_ff @(posedge S_AXI_ACLK or negedge S_AXI_ARESETN) begin
            if (!S_AXI_ARESETN) begin
                tx_wp_q  <= '0;
                tx_rp_q  <= '0;
                tx_cnt_q <= '0;
                rx_wp_q  <= '0;
                rx_rp_q  <= '0;
                rx_cnt_q <= '0;
            end else if (flush) begin
                // Flush overrides any same-edge push or pop on this channel.
                tx_wp_q  <= '0;
                tx_rp_q  <= '0;
                tx_cnt_q <= '0;
                rx_wp_q  <= '0;
                rx_rp_q  <= '0;
                rx_cnt_q <= '0;
            end else begin
                if (tx_push) tx_wp_q <= tx_wp_q + PTR_W'(1);
                if (tx_pop)  tx_rp_q <= tx_rp_q + PTR_W'(1);
                tx_cnt_q <= tx_cnt_q + CNT_W'(tx_push) - CNT_W'(tx_pop);
                if (rx_push) rx_wp_q <= rx_wp_q + PTR_W'(1);
                if (rx_pop)  rx_rp_q <= rx_rp_q + PTR_W'(1);
                rx_cnt_q <= rx_cnt_q + CNT_W'(rx_push) - CNT_W'(rx_pop);
            end
        end

        // Sticky flags: a set event on the same edge as a clear wins.
        always_ff @(posedge S_AXI_ACLK or negedge S_AXI_ARESETN) begin
            if (!S_AXI_ARESETN) begin
                tx_drop_q <= 1'b0;
                rx_unf_q  <= 1'b0;
            end else begin
                if (tx_push_req && !tx_push) begin
                    tx_drop_q <= 1'b1;
                end else if (wr_fire && (widx == IDX_STATUS) && S_AXI_WDATA[8+c]) begin
                    tx_drop_q <= 1'b0;
                end
                if (rx_pop_req && (rx_cnt_q == '0)) begin
                    rx_unf_q <= 1'b1;
                end else if (wr_fire && (widx == IDX_STATUS) && S_AXI_WDATA[12+c]) begin
                    rx_unf_q <= 1'b0;
                end
            end
        end

        // NOTE: FIFO storage is deliberately left out of reset; pointers and
        // counts decide which entries are valid, so the array can map to RAM.
        always_ff @(posedge S_AXI_ACLK) begin
            if (tx_push) tx_mem[tx_wp_q] <= S_AXI_WDATA[TIS_DATA_WIDTH-1:0];
            if (rx_push) rx_mem[rx_wp_q] <= rx_data[c*TIS_DATA_WIDTH +: TIS_DATA_WIDTH];
        end

        assign tx_data[c*TIS_DATA_WIDTH +: TIS_DATA_WIDTH] = tx_mem[tx_rp_q];
        assign tx_valid[c]    = (tx_cnt_q != '0);
        assign rx_ready[c]    = rx_rdy;
        assign rx_nonempty[c] = (rx_cnt_q != '0);
        assign tx_notfull[c]  = (tx_cnt_q != DEPTH_C);
        assign tx_drop[c]     = tx_drop_q;
        assign rx_unf[c]      = rx_unf_q;
        assign rx_head[c]     = rx_mem[rx_rp_q];
        assign rx_count[c]    = rx_cnt_q;
    end

    // -------------------------------------------------------------------------
    // Read data mux (value captured on the ARREADY edge)
    // -------------------------------------------------------------------------
    // NOTE: rd_val gets a default before the case so no path infers a latch.
    always_comb begin
        rd_val = '0;
        case (ridx)
            IDX_STATUS: begin
                for (int i = 0; i < N_CHAN; i++) begin
                    rd_val[i]    = rx_nonempty[i];
                    rd_val[4+i]  = tx_notfull[i];
                    rd_val[8+i]  = tx_drop[i];
                    rd_val[12+i] = rx_unf[i];
                end
            end
            IDX_IRQ_EN: rd_val[8:0] = irq_en_q;
            IDX_LEVEL: begin
                for (int i = 0; i < N_CHAN; i++) rd_val[8*i +: 8] = 8'(rx_count[i]);
            end
            default: begin
                // DATA words; an empty FIFO or absent channel reads as 0.
                for (int i = 0; i < N_CHAN; i++) begin
                    if ((ridx == 4'(i)) && rx_nonempty[i]) begin
                        rd_val = {{(32-TIS_DATA_WIDTH){rx_head[i][TIS_DATA_WIDTH-1]}}, rx_head[i]};
                    end
                end
            end
        endcase
    end

    assign irq_d = (|(irq_en_q[N_CHAN-1:0] & rx_nonempty))
                 | (|(irq_en_q[4 +: N_CHAN] & tx_notfull))
                 | (irq_en_q[8] & (|{tx_drop, rx_unf}));

    // -------------------------------------------------------------------------
    // AXI handshakes, IRQ_EN and interrupt register
    // -------------------------------------------------------------------------
    always_ff @(posedge S_AXI_ACLK or negedge S_AXI_ARESETN) begin
        if (!S_AXI_ARESETN) begin
            awready_q  <= 1'b0;
            wready_q   <= 1'b0;
            bvalid_q   <= 1'b0;
            arready_q  <= 1'b0;
            rvalid_q   <= 1'b0;
            rdata_q    <= '0;
            irq_en_q   <= '0;
            irq_q      <= 1'b0;
            rst_done_q <= 1'b0;
        end else begin
            rst_done_q <= 1'b1;
            awready_q  <= wr_fire;
            wready_q   <= wr_fire;
            if (awready_q) begin
                bvalid_q <= 1'b1;
            end else if (bvalid_q && S_AXI_BREADY) begin
                bvalid_q <= 1'b0;
            end
            arready_q <= rd_fire;
            if (rd_fire) rdata_q <= rd_val;
            if (arready_q) begin
                rvalid_q <= 1'b1;
            end else if (rvalid_q && S_AXI_RREADY) begin
                rvalid_q <= 1'b0;
            end
            if (wr_fire && (widx == IDX_IRQ_EN)) irq_en_q <= S_AXI_WDATA[8:0];
            irq_q <= irq_d;
        end
    end

    assign S_AXI_AWREADY = awready_q;
    assign S_AXI_WREADY  = wready_q;
    assign S_AXI_BVALID  = bvalid_q;
    assign S_AXI_BRESP   = 2'b00;
    assign S_AXI_ARREADY = arready_q;
    assign S_AXI_RVALID  = rvalid_q;
    assign S_AXI_RDATA   = rdata_q;
    assign S_AXI_RRESP   = 2'b00;
    assign irq           = irq_q;

    // Protection, strobes and byte-offset address bits carry no meaning here.
    logic unused_ok;
    assign unused_ok = ^{S_AXI_AWADDR, S_AXI_ARADDR, S_AXI_AWPROT, S_AXI_ARPROT,
                         S_AXI_WSTRB, S_AXI_WDATA};

endmodule
